// File: rtl/cache_pkg.sv
// Shared state type, width helpers and constants for the set-associative instruction cache.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        FLUSH
    } cache_state_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic int calc_off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int num_sets, input int line_bytes);
        return addr_w - $clog2(num_sets) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bit, tag and line storage with its own tag comparator.
module cache_way_array
    import cache_pkg::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int LINE_BYTES = 32,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IDX_W-1:0]        idx,
    input  logic [TAG_W-1:0]        tag,
    output logic                    hit,
    output logic                    valid,
    output logic [LINE_BYTES*8-1:0] line,
    input  logic                    wr_en,
    input  logic [LINE_BYTES*8-1:0] wr_line,
    input  logic                    clr_en,
    input  logic [IDX_W-1:0]        clr_idx
);

    logic [NUM_SETS-1:0]     valid_bits;
    logic [TAG_W-1:0]        tag_mem  [NUM_SETS];
    logic [LINE_BYTES*8-1:0] data_mem [NUM_SETS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_bits <= '0;
        end else if (clr_en) begin
            valid_bits[clr_idx] <= 1'b0;
        end else if (wr_en) begin
            valid_bits[idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= wr_line;
        end
    end

    assign valid = valid_bits[idx];
    assign hit   = valid && (tag_mem[idx] == tag);
    assign line  = data_mem[idx];

endmodule

// File: rtl/set_assoc_icache.sv
// N-way set-associative read-only instruction cache with miss refill, round-robin
// replacement, set-by-set flush and saturating hit/miss statistics.
module set_assoc_icache
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SETS   = 8,
    parameter int WAYS       = 2,
    parameter int LINE_BYTES = 32,
    parameter int DATA_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    req_ready,
    input  logic                    flush,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [DATA_W-1:0]       resp_data,
    output logic                    mem_req_valid,
    output logic [ADDR_W-1:0]       mem_req_addr,
    input  logic                    mem_req_ready,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int OFF_W  = calc_off_w(LINE_BYTES);
    localparam int IDX_W  = calc_idx_w(NUM_SETS);
    localparam int TAG_W  = calc_tag_w(ADDR_W, NUM_SETS, LINE_BYTES);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = LINE_BYTES * 8;

    cache_state_t state, next_state;

    logic [ADDR_W-1:0]               addr_q;
    logic                            flush_pending;
    logic                            start_flush;
    logic [IDX_W-1:0]                flush_idx;
    logic [NUM_SETS-1:0][WAY_W-1:0]  rr_ptr;
    logic [31:0]                     hit_cnt_q;
    logic [31:0]                     miss_cnt_q;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign off = addr_q[OFF_W-1:0];
    assign idx = addr_q[OFF_W +: IDX_W];
    assign tag = addr_q[ADDR_W-1 -: TAG_W];

    logic [WAYS-1:0]   way_hit;
    logic [WAYS-1:0]   way_valid;
    logic [WAYS-1:0]   way_wr;
    logic [LINE_W-1:0] way_line [WAYS];
    logic              clr_en;
    logic              refill;

    assign clr_en = (state == FLUSH);
    assign refill = (state == MISS_WAIT) && mem_resp_valid;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .NUM_SETS  (NUM_SETS),
            .LINE_BYTES(LINE_BYTES),
            .TAG_W     (TAG_W),
            .IDX_W     (IDX_W)
        ) u_way (
            .clk    (clk),
            .reset  (reset),
            .idx    (idx),
            .tag    (tag),
            .hit    (way_hit[w]),
            .valid  (way_valid[w]),
            .line   (way_line[w]),
            .wr_en  (way_wr[w]),
            .wr_line(mem_resp_data),
            .clr_en (clr_en),
            .clr_idx(flush_idx)
        );
    end

    logic              any_hit;
    logic [LINE_W-1:0] hit_line;

    always_comb begin
        any_hit  = 1'b0;
        hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_line = hit_line | way_line[w];
            end
        end
    end

    // Lowest-index empty way wins; the round-robin pointer only decides among full sets.
    logic             all_valid;
    logic [WAY_W-1:0] victim;

    always_comb begin
        all_valid = &way_valid;
        victim    = rr_ptr[idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = WAY_W'(w);
        end
        way_wr = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_wr[w] = refill && (victim == WAY_W'(w));
        end
    end

    logic wants_flush;
    assign wants_flush = flush || flush_pending;

    always_comb begin
        next_state    = state;
        start_flush   = 1'b0;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_hit      = 1'b0;
        resp_data     = '0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                if (wants_flush) begin
                    next_state  = FLUSH;
                    start_flush = 1'b1;
                end else begin
                    req_ready = !reset;
                    if (req_valid && !reset) next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (any_hit) begin
                    resp_valid  = 1'b1;
                    resp_hit    = 1'b1;
                    resp_data   = hit_line[{off, 3'b000} +: DATA_W];
                    next_state  = wants_flush ? FLUSH : IDLE;
                    start_flush = wants_flush;
                end else begin
                    next_state = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) next_state = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    resp_valid  = 1'b1;
                    resp_data   = mem_resp_data[{off, 3'b000} +: DATA_W];
                    next_state  = wants_flush ? FLUSH : IDLE;
                    start_flush = wants_flush;
                end
            end
            FLUSH: begin
                if (flush_idx == IDX_W'(NUM_SETS - 1)) begin
                    next_state  = wants_flush ? FLUSH : IDLE;
                    start_flush = wants_flush;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign mem_req_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            flush_pending <= 1'b0;
            flush_idx     <= '0;
            rr_ptr        <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && req_ready && req_valid) addr_q <= req_addr;
            // A flush that arrives mid-operation is remembered until the operation ends.
            if (start_flush) begin
                flush_pending <= 1'b0;
            end else if (flush && state != IDLE) begin
                flush_pending <= 1'b1;
            end
            if (state == FLUSH) flush_idx <= flush_idx + 1'b1;
            if (state == FLUSH) begin
                rr_ptr[flush_idx] <= '0;
            end else if (refill && all_valid) begin
                rr_ptr[idx] <= (rr_ptr[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[idx] + 1'b1;
            end
            if (state == LOOKUP && any_hit && hit_cnt_q != CNT_MAX) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state == LOOKUP && !any_hit && miss_cnt_q != CNT_MAX) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_icache.sv
// Scoreboard bench for set_assoc_icache: directed scenarios plus random fetches checked
// against a line-address-level reference model and a reactive memory responder.
module tb_set_assoc_icache;

    localparam int ADDR_W     = 32;
    localparam int NUM_SETS   = 8;
    localparam int WAYS       = 2;
    localparam int LINE_BYTES = 32;
    localparam int DATA_W     = 8;
    localparam int LINE_W     = LINE_BYTES * 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              flush;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_data;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_data;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    set_assoc_icache #(
        .ADDR_W(ADDR_W), .NUM_SETS(NUM_SETS), .WAYS(WAYS),
        .LINE_BYTES(LINE_BYTES), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .flush(flush),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [7:0] data;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_mem_q[$];

    // Reference model: each set holds up to WAYS resident line addresses.
    logic [31:0] m_line  [NUM_SETS][WAYS];
    bit          m_valid [NUM_SETS][WAYS];
    int          m_rr    [NUM_SETS];
    int          m_hits;
    int          m_misses;

    bit auto_mem          = 1'b1;
    int force_ready_delay = -1;
    int force_resp_delay  = -1;
    bit flush_in_wait     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] la, input int i);
        logic [31:0] mix;
        mix = 32'(la[31:12]) * 32'd37;
        return 8'(i) + mix[7:0];
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_BYTES; i++) l[i*8 +: 8] = mem_byte(la, i);
        return l;
    endfunction

    task automatic modelFlush();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic modelReset();
        modelFlush();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic modelAccess(input logic [31:0] a, output exp_t e, output bit miss);
        int          s;
        int          victim;
        logic [31:0] la;
        s      = int'((a / LINE_BYTES) % NUM_SETS);
        la     = a - (a % LINE_BYTES);
        victim = -1;
        miss   = 1'b1;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_line[s][w] == la) miss = 1'b0;
        if (miss) begin
            for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && victim < 0) victim = w;
            if (victim < 0) begin
                victim  = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][victim] = 1'b1;
            m_line[s][victim]  = la;
            m_misses++;
        end else begin
            m_hits++;
        end
        e.hit  = !miss;
        e.data = mem_byte(la, int'(a % LINE_BYTES));
    endtask

    task automatic applyStimulus(input logic [31:0] a);
        exp_t e;
        bit   miss;
        int   n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        @(negedge clk);
        while (!req_ready) begin
            n++;
            if (n > 100) begin
                failNow("accept_timeout", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        modelAccess(a, e, miss);
        exp_q.push_back(e);
        if (miss) exp_mem_q.push_back(a - (a % LINE_BYTES));
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!miss) begin
            @(negedge clk);
            checkOutput("hit_latency", 32'(resp_valid), 32'd1);
        end
        n = 0;
        while (exp_q.size() != 0) begin
            n++;
            if (n > 200) begin
                failNow("resp_timeout", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
                exp_mem_q.delete();
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkCounters();
        @(negedge clk);
        checkOutput("hit_count", hit_count, 32'(m_hits));
        checkOutput("miss_count", miss_count, 32'(m_misses));
    endtask

    task automatic pulseFlush();
        @(posedge clk); #1;
        flush = 1'b1;
        modelFlush();
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Monitor: every response strobe is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    failNow("unexpected_resp", 32'(resp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_hit", 32'(resp_hit), 32'(e.hit));
                    checkOutput("resp_data", 32'(resp_data), 32'(e.data));
                end
            end
        end
    end

    // Memory responder with randomised handshake delays.
    initial begin
        logic [31:0] la;
        int          rd;
        int          sd;
        bit          fw;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_req_valid && !reset) begin
                la = mem_req_addr;
                fw = flush_in_wait;
                rd = (force_ready_delay >= 0) ? force_ready_delay : int'($urandom_range(0, 3));
                sd = (force_resp_delay >= 0) ? force_resp_delay : int'($urandom_range(0, 3));
                if (exp_mem_q.size() == 0) failNow("unexpected_mem_req", la, 32'd0);
                else checkOutput("mem_req_addr", la, exp_mem_q.pop_front());
                for (int i = 0; i < rd; i++) begin
                    @(negedge clk);
                    checkOutput("mem_req_hold_valid", 32'(mem_req_valid), 32'd1);
                    checkOutput("mem_req_hold_addr", mem_req_addr, la);
                    checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
                end
                @(posedge clk); #1;
                mem_req_ready = 1'b1;
                @(posedge clk); #1;
                mem_req_ready = 1'b0;
                if (fw) begin
                    flush = 1'b1;
                    modelFlush();
                    @(posedge clk); #1;
                    flush = 1'b0;
                end
                for (int i = 0; i < sd; i++) begin
                    @(posedge clk); #1;
                end
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_line(la);
                @(posedge clk); #1;
                mem_resp_valid = 1'b0;
                if (fw) begin
                    for (int i = 0; i < NUM_SETS; i++) begin
                        @(negedge clk);
                        checkOutput("flush_busy_ready", 32'(req_ready), 32'd0);
                    end
                    @(negedge clk);
                    checkOutput("flush_done_ready", 32'(req_ready), 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        flush     = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_hit_count", hit_count, 32'd0);
        checkOutput("rst_miss_count", miss_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

        $display("[TB] cold miss then hit");
        applyStimulus(32'h0000_0123);
        checkCounters();
        applyStimulus(32'h0000_0125);
        checkCounters();

        $display("[TB] conflict sequence in set 1");
        pulseFlush();
        applyStimulus(32'h0000_1020);
        applyStimulus(32'h0000_2020);
        applyStimulus(32'h0000_3020);
        applyStimulus(32'h0000_2020);
        applyStimulus(32'h0000_1020);
        applyStimulus(32'h0000_3020);
        applyStimulus(32'h0000_2020);
        checkCounters();

        $display("[TB] memory backpressure");
        force_ready_delay = 5;
        applyStimulus(32'h0000_0660);
        force_ready_delay = -1;
        checkCounters();

        $display("[TB] flush during refill wait");
        force_resp_delay = 2;
        flush_in_wait    = 1'b1;
        applyStimulus(32'h0000_0444);
        flush_in_wait    = 1'b0;
        force_resp_delay = -1;
        applyStimulus(32'h0000_0444);
        checkCounters();

        $display("[TB] random fetches");
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) pulseFlush();
            a = ($urandom_range(0, 3) << 12) | $urandom_range(0, 255);
            applyStimulus(a);
            if (i % 25 == 24) checkCounters();
        end
        checkCounters();

        $display("[TB] reset during refill request");
        auto_mem = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_5040;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        checkOutput("miss_req_seen", 32'(mem_req_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_mem_req_drop", 32'(mem_req_valid), 32'd0);
        checkOutput("rst2_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst2_hit_count", hit_count, 32'd0);
        checkOutput("rst2_miss_count", miss_count, 32'd0);
        modelReset();
        exp_q.delete();
        exp_mem_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset2", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_line(32'h0000_5040);
        @(negedge clk);
        checkOutput("late_resp_ignored", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        auto_mem = 1'b1;
        applyStimulus(32'h0000_5044);
        checkCounters();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/set_assoc_icache.md
Name: set_assoc_icache

Overview:
Parametrised N-way set-associative read-only cache for the instruction-fetch path. It is the successor to the fixed 8-line direct-indexed cache: way count, set count, line size and fetch width are generalised. It adds a miss-refill state machine with a memory handshake, replacement policy, flush, and hit/miss statistics. It sits between the PC/fetch stage and the backing instruction memory.

Parameters:
ADDR_W, 32, address width in bits
NUM_SETS, 8, number of sets; power of 2, at least 2
WAYS, 2, associativity; power of 2, from 1 to 8
LINE_BYTES, 32, line size in bytes; power of 2, at least 4
DATA_W, 8, fetch data width in bits; must equal 8 (one byte per fetch)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  fetch request present
req_addr  in  ADDR_W  byte address (PC)
req_ready  out  1  cache can accept a request this cycle
flush  in  1  one-cycle pulse; invalidate all lines
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  response was a hit (0 means it was served after a refill)
resp_data  out  DATA_W  fetched byte
mem_req_valid  out  1  line refill request
mem_req_addr  out  ADDR_W  line-aligned refill address (offset bits are 0)
mem_req_ready  in  1  memory accepts the request
mem_resp_valid  in  1  refill line data valid
mem_resp_data  in  LINE_BYTES*8  full refill line; byte 0 is in bits [7:0]
hit_count  out  32  saturating count of hits
miss_count  out  32  saturating count of misses

Behaviour:
- Address split: offset = addr[OFF_W-1:0], where OFF_W = log2(LINE_BYTES). Index = next IDX_W = log2(NUM_SETS) bits. Tag = the remaining upper bits (24 bits at defaults, so index = addr[7:5]).
- Reset (asynchronous): all valid bits cleared, all victim pointers set to 0, FSM goes to IDLE, counters cleared. Output values in reset: req_ready=0, resp_valid=0, resp_hit=0, resp_data=0, mem_req_valid=0. req_ready rises in the first cycle after reset deasserts.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FLUSH.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid and req_ready are both 1. The address is latched and the FSM moves to LOOKUP.
  - flush has priority over a request in the same cycle: the request is not accepted, req_ready is 0 in that cycle, and the FSM moves to FLUSH.
- LOOKUP:
  - Compares the latched tag against all WAYS in parallel; a way matches only if its valid bit is set.
  - Hit: resp_valid=1, resp_hit=1, resp_data = selected byte, hit_count increments. Returns to IDLE. Hit latency is 1 cycle after acceptance; back-to-back hits are accepted every 2 cycles.
  - Miss: miss_count increments, FSM goes to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1 with a line-aligned address.
  - mem_req_valid and mem_req_addr are held stable until mem_req_ready is seen; then the FSM moves to MISS_WAIT.
- MISS_WAIT:
  - Waits for mem_resp_valid.
  - Victim selection: the lowest-index invalid way if one exists; otherwise the set's round-robin pointer, which then increments modulo WAYS. The pointer advances only when a valid line is evicted.
  - Writes data, tag and valid into the victim way.
  - In the same cycle drives resp_valid=1, resp_hit=0, and resp_data taken directly from mem_resp_data at the offset. Returns to IDLE.
  - mem_resp_valid outside MISS_WAIT is ignored.
- flush while not in IDLE: latched into a pending bit and serviced on return to IDLE, before any new request.
- FLUSH: clears valid bits for one set per cycle, sets 0 to NUM_SETS-1, so it takes NUM_SETS cycles. Victim pointers are reset. req_ready=0 throughout. Counters are unaffected.
- Counters saturate at 0xFFFF_FFFF.
- Reset asserted mid-miss: mem_req_valid drops immediately and the outstanding refill is abandoned. A late mem_resp_valid after reset is ignored because the FSM is in IDLE.

Decomposition:
- Package cache_pkg holds:
  - the state enum cache_state_t
  - the derived-width helpers OFF_W, IDX_W and TAG_W (computed with $clog2)
  - the constant CNT_MAX
- Sub-module cache_way_array holds one way: valid bits, tag and line storage for NUM_SETS sets, plus the per-way tag compare. It is instantiated WAYS times from a generate loop.
- The top level holds the FSM, victim pointers, hit mux and counters.

Test Plan:
- Cold miss: after reset, request 0x0000_0123 with memory line bytes = index values → mem_req_addr=0x0000_0120, resp_hit=0, resp_data=0x03, miss_count=1.
- Repeat 0x0000_0125 → resp_valid exactly 1 cycle after acceptance, resp_hit=1, resp_data=0x05, hit_count=1, no mem_req_valid.
- Conflict, WAYS=2: fill tags A, B, C into index 1 (addresses 0x1020, 0x2020, 0x3020) → C evicts way 0 (A). A re-access of B hits; a re-access of A misses and evicts way 1 (B).
- Backpressure: hold mem_req_ready=0 for 5 cycles → mem_req_valid and mem_req_addr stay stable; req_ready=0; no resp_valid.
- Flush during MISS_WAIT → refill completes and responds, then FLUSH takes 8 cycles with req_ready=0; the next access to the same address misses.
- Reset asserted in MISS_REQ → mem_req_valid goes to 0 asynchronously, counters go to 0, and a subsequent mem_resp_valid produces no resp_valid.
